// File: rtl/core_pkg.sv
// Shared types and opcode decode for the RV32 subset core (R, I-ALU, LUI, CSRRW).
package core_pkg;

  typedef enum logic [2:0] {
    IT_R       = 3'd0,
    IT_I       = 3'd1,
    IT_U       = 3'd2,
    IT_CSRRW   = 3'd3,
    IT_ILLEGAL = 3'd4
  } inst_type_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_WAIT      = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  localparam logic [6:0]  OPC_OP       = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0]  OPC_LUI      = 7'b0110111;
  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;
  localparam logic [2:0]  FUNCT3_CSRRW = 3'b001;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  function automatic inst_type_e classify(input logic [6:0] opcode, input logic [2:0] funct3);
    inst_type_e t;
    case (opcode)
      OPC_OP:    t = IT_R;
      OPC_OPIMM: t = IT_I;
      OPC_LUI:   t = IT_U;
      OPC_SYSTEM: begin
        if (funct3 == FUNCT3_CSRRW) t = IT_CSRRW;
        else                        t = IT_ILLEGAL;
      end
      default:   t = IT_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer; sole owner of the PC.
// All outputs are registered from the next-state decode so they are clean during reset.
module instr_sequencer
  import core_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32'd12,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst_q,
  output logic [ADDR_W-1:0] pc,
  output logic              rf_re,
  output logic              alu_en,
  output logic              rf_we,
  output logic              csr_we,
  output logic              halted,
  output logic              retired
);

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};

  state_e            state_r, next_state_s;
  logic [31:0]       inst_q_r;
  logic [ADDR_W-1:0] pc_r;
  logic              imem_req_r, rf_re_r, alu_en_r, rf_we_r, csr_we_r, halted_r, retired_r;
  logic              imem_req_s, rf_re_s, alu_en_s, rf_we_s, csr_we_s, halted_s, retired_s;
  inst_type_e        inst_type_s;
  logic              accept_s;

  // Next-state and next-output decode
  always_comb begin
    inst_type_s  = classify(inst_q_r[6:0], inst_q_r[14:12]);
    // A request must already be on the bus; this drops rvalid left over from before reset.
    accept_s     = ((state_r == ST_FETCH) || (state_r == ST_WAIT)) && imem_req_r && imem_rvalid;
    next_state_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (!imem_req_r)   next_state_s = ST_FETCH;
        else if (accept_s) next_state_s = ST_DECODE;
        else               next_state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (accept_s) next_state_s = ST_DECODE;
        else          next_state_s = ST_WAIT;
      end
      ST_DECODE: begin
        if (inst_type_s == IT_ILLEGAL) next_state_s = ST_TRAP;
        else                           next_state_s = ST_EXECUTE;
      end
      ST_EXECUTE:   next_state_s = ST_WRITEBACK;
      ST_WRITEBACK: next_state_s = ST_FETCH;
      ST_TRAP:      next_state_s = ST_TRAP;
      default:      next_state_s = ST_TRAP;
    endcase

    imem_req_s = (next_state_s == ST_FETCH) || (next_state_s == ST_WAIT);
    rf_re_s    = (next_state_s == ST_DECODE);
    alu_en_s   = (next_state_s == ST_EXECUTE) && (inst_type_s != IT_CSRRW);
    csr_we_s   = (next_state_s == ST_EXECUTE) && (inst_type_s == IT_CSRRW);
    rf_we_s    = (next_state_s == ST_WRITEBACK) && (inst_q_r[11:7] != 5'd0);
    retired_s  = (next_state_s == ST_WRITEBACK);
    halted_s   = (next_state_s == ST_TRAP);
  end

  // FSM state, registered strobes, instruction latch and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_FETCH;
      inst_q_r   <= INST_NOP;
      pc_r       <= RESET_PC;
      imem_req_r <= 1'b0;
      rf_re_r    <= 1'b0;
      alu_en_r   <= 1'b0;
      rf_we_r    <= 1'b0;
      csr_we_r   <= 1'b0;
      retired_r  <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      imem_req_r <= imem_req_s;
      rf_re_r    <= rf_re_s;
      alu_en_r   <= alu_en_s;
      rf_we_r    <= rf_we_s;
      csr_we_r   <= csr_we_s;
      retired_r  <= retired_s;
      halted_r   <= halted_s;
      if (accept_s) inst_q_r <= imem_rdata;
      else          inst_q_r <= inst_q_r;
      if (state_r == ST_WRITEBACK) pc_r <= pc_r + PC_STEP;
      else                         pc_r <= pc_r;
    end
  end

  assign imem_req  = imem_req_r;
  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign inst_q    = inst_q_r;
  assign rf_re     = rf_re_r;
  assign alu_en    = alu_en_r;
  assign rf_we     = rf_we_r;
  assign csr_we    = csr_we_r;
  assign retired   = retired_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; cycle k is sampled at the negedge after the k-th posedge following reset release.
module tb_instr_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, rf_re, alu_en, rf_we, csr_we, halted, retired;
  logic [11:0] imem_addr, pc;
  logic [31:0] inst_q;

  logic        rst_w_n, w_rvalid;
  logic [31:0] w_rdata;
  logic        w_req, w_rf_re, w_alu_en, w_rf_we, w_csr_we, w_halted, w_retired;
  logic [11:0] w_addr, w_pc;
  logic [31:0] w_inst_q;

  int n_cmp;
  int n_err;

  instr_sequencer #(.ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_q(inst_q), .pc(pc),
    .rf_re(rf_re), .alu_en(alu_en), .rf_we(rf_we), .csr_we(csr_we),
    .halted(halted), .retired(retired)
  );

  instr_sequencer #(.ADDR_W(12), .RESET_PC(12'hFFC)) dut_w (
    .clk(clk), .rst_n(rst_w_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .inst_q(w_inst_q), .pc(w_pc),
    .rf_re(w_rf_re), .alu_en(w_alu_en), .rf_we(w_rf_we), .csr_we(w_csr_we),
    .halted(w_halted), .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL reset_pc: got %h exp 000", pc); end
    n_cmp++; if (inst_q !== NOP) begin n_err++; $display("FAIL reset_inst_q: got %h exp %h", inst_q, NOP); end
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b exp 0", halted); end
    n_cmp++; if ({rf_re, alu_en, rf_we, csr_we, retired} !== 5'b00000) begin
      n_err++; $display("FAIL reset_strobes: got %b exp 00000", {rf_re, alu_en, rf_we, csr_we, retired}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b exp 1", imem_req); end
    n_cmp++; if (imem_addr !== 12'h000) begin n_err++; $display("FAIL first_addr: got %h exp 000", imem_addr); end
  endtask

  task automatic test_r_type();
    int re_c, alu_c, we_c, ret_c, re_n, alu_n, we_n, ret_n, csr_n, multi;
    logic [11:0] addr1;
    re_c = 0; alu_c = 0; we_c = 0; ret_c = 0; re_n = 0; alu_n = 0; we_n = 0; ret_n = 0; csr_n = 0; multi = 0;
    addr1 = 12'hFFF;
    imem_rdata = 32'h0020_81B3;
    imem_rvalid = 1'b1;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) addr1 = imem_addr;
      if (rf_re)   begin re_n++;  re_c = c;  end
      if (alu_en)  begin alu_n++; alu_c = c; end
      if (rf_we)   begin we_n++;  we_c = c;  end
      if (retired) begin ret_n++; ret_c = c; end
      if (csr_we)  csr_n++;
      if (int'(rf_re) + int'(alu_en) + int'(rf_we) + int'(csr_we) > 1) multi++;
    end
    tick();
    n_cmp++; if (addr1 !== 12'h000) begin n_err++; $display("FAIL r_addr: got %h exp 000", addr1); end
    n_cmp++; if (re_c != 2 || re_n != 1) begin n_err++; $display("FAIL r_rf_re: got cyc %0d cnt %0d exp cyc 2 cnt 1", re_c, re_n); end
    n_cmp++; if (alu_c != 3 || alu_n != 1) begin n_err++; $display("FAIL r_alu_en: got cyc %0d cnt %0d exp cyc 3 cnt 1", alu_c, alu_n); end
    n_cmp++; if (we_c != 4 || we_n != 1) begin n_err++; $display("FAIL r_rf_we: got cyc %0d cnt %0d exp cyc 4 cnt 1", we_c, we_n); end
    n_cmp++; if (ret_c != 4 || ret_n != 1) begin n_err++; $display("FAIL r_retired: got cyc %0d cnt %0d exp cyc 4 cnt 1", ret_c, ret_n); end
    n_cmp++; if (csr_n != 0) begin n_err++; $display("FAIL r_csr_we: got %0d exp 0", csr_n); end
    n_cmp++; if (multi != 0) begin n_err++; $display("FAIL r_onehot: got %0d overlaps exp 0", multi); end
    n_cmp++; if (pc !== 12'h004) begin n_err++; $display("FAIL r_pc: got %h exp 004", pc); end
  endtask

  task automatic test_wait_states();
    int req_n, bad_addr, ret_c, we_c;
    logic [31:0] iq4, iq5, iq7;
    req_n = 0; bad_addr = 0; ret_c = 0; we_c = 0;
    iq4 = 32'h0; iq5 = 32'h0; iq7 = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    apply_reset();
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (imem_req) begin req_n++; if (imem_addr !== 12'h000) bad_addr++; end
      if (retired) ret_c = c;
      if (rf_we) we_c = c;
      if (c == 4) iq4 = inst_q;
      if (c == 5) iq5 = inst_q;
      if (c == 7) iq7 = inst_q;
      imem_rvalid = (c == 4);
      imem_rdata = (c == 4) ? 32'h0050_0093 : 32'hFFFF_FFFF;
    end
    n_cmp++; if (req_n != 4) begin n_err++; $display("FAIL ws_req_cycles: got %0d exp 4", req_n); end
    n_cmp++; if (bad_addr != 0) begin n_err++; $display("FAIL ws_addr_stable: got %0d bad exp 0", bad_addr); end
    n_cmp++; if (iq4 !== NOP) begin n_err++; $display("FAIL ws_inst_hold: got %h exp %h", iq4, NOP); end
    n_cmp++; if (iq5 !== 32'h0050_0093) begin n_err++; $display("FAIL ws_inst_latch: got %h exp 00500093", iq5); end
    n_cmp++; if (iq7 !== 32'h0050_0093) begin n_err++; $display("FAIL ws_inst_keep: got %h exp 00500093", iq7); end
    n_cmp++; if (ret_c != 7) begin n_err++; $display("FAIL ws_retire: got cyc %0d exp 7", ret_c); end
    n_cmp++; if (we_c != 7) begin n_err++; $display("FAIL ws_rf_we: got cyc %0d exp 7", we_c); end
  endtask

  task automatic test_csrrw();
    int csr_c, csr_n, alu_n, we_n, ret_n;
    csr_c = 0; csr_n = 0; alu_n = 0; we_n = 0; ret_n = 0;
    imem_rdata = 32'h3401_1073;
    imem_rvalid = 1'b1;
    apply_reset();
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (csr_we) begin csr_n++; csr_c = c; end
      if (alu_en) alu_n++;
      if (rf_we) we_n++;
      if (retired) ret_n++;
    end
    tick();
    n_cmp++; if (csr_n != 1 || csr_c != 3) begin n_err++; $display("FAIL csr_we: got cyc %0d cnt %0d exp cyc 3 cnt 1", csr_c, csr_n); end
    n_cmp++; if (alu_n != 0) begin n_err++; $display("FAIL csr_alu_en: got %0d exp 0", alu_n); end
    n_cmp++; if (we_n != 0) begin n_err++; $display("FAIL csr_rf_we: got %0d exp 0", we_n); end
    n_cmp++; if (ret_n != 1) begin n_err++; $display("FAIL csr_retired: got %0d exp 1", ret_n); end
    n_cmp++; if (pc !== 12'h004) begin n_err++; $display("FAIL csr_pc: got %h exp 004", pc); end
  endtask

  task automatic test_trap();
    int halt_c, req_n, pc_bad, ret_n, act_n;
    halt_c = 0; req_n = 0; pc_bad = 0; ret_n = 0; act_n = 0;
    imem_rdata = NOP;
    imem_rvalid = 1'b1;
    apply_reset();
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (halted && halt_c == 0) halt_c = c;
      if (c >= 7 && imem_req) req_n++;
      if (c >= 5 && pc !== 12'h004) pc_bad++;
      if (retired) ret_n++;
      if (c >= 7 && (rf_re || alu_en || rf_we || csr_we)) act_n++;
      if (c == 4) imem_rdata = 32'h0000_0003;
    end
    n_cmp++; if (halt_c != 7) begin n_err++; $display("FAIL trap_halt_cycle: got %0d exp 7", halt_c); end
    n_cmp++; if (halted !== 1'b1) begin n_err++; $display("FAIL trap_halted_sticky: got %b exp 1", halted); end
    n_cmp++; if (req_n != 0) begin n_err++; $display("FAIL trap_req: got %0d high cycles exp 0", req_n); end
    n_cmp++; if (pc_bad != 0) begin n_err++; $display("FAIL trap_pc_frozen: got %0d bad cycles exp 0", pc_bad); end
    n_cmp++; if (ret_n != 1) begin n_err++; $display("FAIL trap_retired: got %0d exp 1", ret_n); end
    n_cmp++; if (act_n != 0) begin n_err++; $display("FAIL trap_strobes: got %0d exp 0", act_n); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL trap_reset_halted: got %b exp 0", halted); end
    n_cmp++; if (pc !== 12'h000) begin n_err++; $display("FAIL trap_reset_pc: got %h exp 000", pc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [11:0] a1, a5;
    logic r5;
    a1 = 12'h0; a5 = 12'hFFF; r5 = 1'b0;
    w_rdata = NOP;
    w_rvalid = 1'b1;
    @(negedge clk);
    rst_w_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) a1 = w_addr;
      if (c == 5) begin a5 = w_addr; r5 = w_req; end
    end
    n_cmp++; if (a1 !== 12'hFFC) begin n_err++; $display("FAIL wrap_first_addr: got %h exp ffc", a1); end
    n_cmp++; if (a5 !== 12'h000 || r5 !== 1'b1) begin n_err++; $display("FAIL wrap_second_addr: got %h req %b exp 000 req 1", a5, r5); end
  endtask

  task automatic test_reset_mid_fetch();
    int ret_n, iq_bad;
    ret_n = 0; iq_bad = 0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0050_0093;
    apply_reset();
    tick();
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL mid_wait_req: got %b exp 1", imem_req); end
    #2;
    rst_n = 1'b0;
    imem_rvalid = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL mid_async_drop: got %b exp 0", imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (inst_q !== NOP) begin n_err++; $display("FAIL mid_late_rvalid: got %h exp %h", inst_q, NOP); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 12'h000) begin
      n_err++; $display("FAIL mid_refetch: got req %b addr %h exp req 1 addr 000", imem_req, imem_addr); end
    imem_rvalid = 1'b0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      if (retired) ret_n++;
      if (inst_q !== NOP) iq_bad++;
    end
    n_cmp++; if (ret_n != 0) begin n_err++; $display("FAIL mid_retired: got %0d exp 0", ret_n); end
    n_cmp++; if (iq_bad != 0) begin n_err++; $display("FAIL mid_inst_q: got %0d changed cycles exp 0", iq_bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = NOP;
    rst_w_n = 1'b0;
    w_rvalid = 1'b0;
    w_rdata = NOP;
    repeat (2) @(negedge clk);
    test_reset();
    test_r_type();
    test_wait_states();
    test_csrrw();
    test_trap();
    test_wrap();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
